// File: rtl/bit_serializer_pkg.sv
// Shared types for the bit serializer.
package bit_serializer_pkg;

    // Controller states; SHIFT means a word is in flight.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_serializer_if.sv
// Load / serial handshake bundle for the bit serializer.
// master drives the parallel word and consumes serial bits; slave is the serializer.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             flush;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_bit;
    logic             ser_last;
    logic             busy;

    modport master (
        output load_valid,
        output load_data,
        output flush,
        output ser_ready,
        input  load_ready,
        input  ser_valid,
        input  ser_bit,
        input  ser_last,
        input  busy
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  flush,
        input  ser_ready,
        output load_ready,
        output ser_valid,
        output ser_bit,
        output ser_last,
        output busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-load serializer: accepts one WIDTH-bit word, then presents it one
// bit per accepted transfer, LSB or MSB first.
//
// state | meaning
// IDLE  | no word held; load_ready high, serial outputs forced low
// SHIFT | word in flight; ser_bit is the next bit, advanced on ser_ready
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1
) (
    input logic             clk,
    input logic             rst,
    bit_serializer_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam int               OUT_IDX  = (LSB_FIRST != 0) ? 0 : WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             in_shift;
    logic             last_bit;
    logic             load_ready;
    logic             do_load;
    logic             do_shift;
    logic             do_flush;

    assign in_shift = (state == SHIFT);
    assign last_bit = in_shift && (bit_cnt == LAST_CNT);

    // State register; reset drops any word in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; flush outranks a simultaneous transfer.
    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        do_flush   = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (bus.load_valid && load_ready && !bus.flush) begin
                    do_load   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.flush) begin
                    do_flush  = 1'b1;
                    state_nxt = IDLE;
                end else if (bus.ser_ready) begin
                    do_shift = 1'b1;
                    if (last_bit) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register and bit counter; the counter stops at WIDTH-1 on the
    // final transfer and is cleared by the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (do_load) begin
            shift_reg <= bus.load_data;
            bit_cnt   <= '0;
        end else if (do_flush) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (do_shift) begin
            if (LSB_FIRST != 0) begin
                shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
            end else begin
                shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            end
            if (!last_bit) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs come from registered state only; ser_bit is held low in IDLE.
    assign bus.load_ready = load_ready;
    assign bus.ser_valid  = in_shift;
    assign bus.busy       = in_shift;
    assign bus.ser_bit    = in_shift & shift_reg[OUT_IDX];
    assign bus.ser_last   = last_bit;

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, meaning the number of bits per stored word (legal range 2..32).
REQ-002 Parameter LSB_FIRST, default 1, meaning the bit order: 1 sends bit 0 first, 0 sends bit WIDTH-1 first.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port load_valid  input  1  parallel word offered.
REQ-006 Port load_ready  output  1  block can accept a word.
REQ-007 Port load_data  input  WIDTH  parallel word to serialize.
REQ-008 Port flush  input  1  synchronous abort of the word in flight.
REQ-009 Port ser_valid  output  1  ser_bit holds a valid bit.
REQ-010 Port ser_ready  input  1  consumer accepts the current bit.
REQ-011 Port ser_bit  output  1  current serial bit.
REQ-012 Port ser_last  output  1  current bit is the final bit of the word.
REQ-013 Port busy  output  1  a word is in flight.

Function
REQ-014 FSM states SHALL be IDLE and SHIFT only.
REQ-015 In IDLE: load_ready=1, ser_valid=0, busy=0.
REQ-016 IDLE to SHIFT on the clk edge with load_valid&&load_ready; load_data captured into an internal shift register, bit counter cleared to 0.
REQ-017 In SHIFT: load_ready=0, ser_valid=1, busy=1; load_valid is ignored.
REQ-018 ser_bit = shift register bit 0 when LSB_FIRST=1, bit WIDTH-1 otherwise; driven from registers only, never combinationally from load_data.
REQ-019 A bit transfer occurs on a clk edge with ser_valid&&ser_ready; the register shifts one place toward the output end and the counter increments.
REQ-020 With ser_ready=0, ser_bit, ser_last and the counter SHALL hold unchanged (no bit dropped or repeated).
REQ-021 ser_last = 1 exactly when in SHIFT with counter == WIDTH-1.
REQ-022 The transfer with ser_last=1 returns the FSM to IDLE on the same edge.
REQ-023 A new word SHALL NOT be accepted on the edge of the final bit transfer; minimum period per word is WIDTH+1 cycles.
REQ-024 Counter width SHALL be $clog2(WIDTH); counter never exceeds WIDTH-1 and never wraps.
REQ-025 flush=1 in SHIFT forces IDLE on the next edge and discards remaining bits; it has priority over a simultaneous bit transfer.
REQ-026 flush=1 in IDLE blocks the load and leaves the block in IDLE.
REQ-027 The output value in IDLE is don't-care but SHALL be 0.

Reset
REQ-028 rst=1 SHALL immediately, without a clk edge, force IDLE, counter=0, shift register=0, ser_valid=0, ser_bit=0, ser_last=0, busy=0, load_ready=1.
REQ-029 Reset during SHIFT discards the word; the first edge after rst deasserts behaves as IDLE.

Structure
REQ-030 The FSM state enum (IDLE, SHIFT) SHALL be defined in a shared package, bit_serializer_pkg.
REQ-031 The implementation SHALL be one flat module with no sub-modules.

Verification
REQ-032 WIDTH=8, LSB_FIRST=1, ser_ready=1, load 0x1E -> ser_bit 0,1,1,1,1,0,0,0 on consecutive cycles, ser_last only on the 8th bit, load_ready high again the next cycle.
REQ-033 LSB_FIRST=0, load 0x1E -> ser_bit 0,0,0,1,1,1,1,0.
REQ-034 Load 0xFF and hold ser_ready=0 for 3 cycles after the 2nd bit -> bit and counter held for 3 cycles, exactly 8 transfers in total, no duplicates.
REQ-035 Assert rst asynchronously between edges after the 4th bit -> ser_valid and busy go to 0 at once, and a following load of 0x01 sends 1,0,0,0,0,0,0,0.
REQ-036 Assert flush together with ser_ready on the 5th bit -> IDLE next cycle, no further ser_valid, and the next load is accepted.
REQ-037 load_valid held high across back-to-back words 0xAA then 0x55 -> one idle cycle between the words, and the second word is sent intact starting with bit 1.
